// File: rtl/tone_window_scheduler.sv
// Tone-window scheduler: counts band-pass comparator edges per measurement window,
// confirms the dominant tone over consecutive windows and arbitrates it against manual pushbuttons.
module tone_window_scheduler #(
    parameter int WINDOW_CYCLES = 50000,
    parameter int CNT_W         = 16,
    parameter int MIN_EDGES     = 10,
    parameter int CONFIRM       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [4:0] bp,
    input  logic [3:0] pb,
    output logic [2:0] dir,
    output logic       dir_valid,
    output logic       source,
    output logic       window_done
);

    localparam int WC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int ST_W = $clog2(CONFIRM + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_EVAL    = 2'd2;

    logic [4:0]       bp_s1, bp_s2, bp_prev;
    logic [3:0]       pb_s1, pb_s2;
    logic [4:0]       bp_edge;

    logic [1:0]       state, state_nx;
    logic [WC_W-1:0]  wcnt;
    logic             last_cycle;
    logic [CNT_W-1:0] cnt [5];

    logic [2:0]       win_code;
    logic [CNT_W-1:0] win_cnt;

    logic [2:0]       cand, cand_nx;
    logic [ST_W-1:0]  streak, streak_nx;
    logic [2:0]       tone_dir, tone_dir_nx;
    logic             tone_valid, tone_valid_nx;

    logic [2:0]       man_code;
    logic             man_active;

    // bp keeps a third stage so rising edges are found on the already-synchronised signal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_s1   <= '0;
            bp_s2   <= '0;
            bp_prev <= '0;
            pb_s1   <= '0;
            pb_s2   <= '0;
        end else begin
            bp_s1   <= bp;
            bp_s2   <= bp_s1;
            bp_prev <= bp_s2;
            pb_s1   <= pb;
            pb_s2   <= pb_s1;
        end
    end

    assign bp_edge    = bp_s2 & ~bp_prev;
    assign last_cycle = (state == S_MEASURE) && (wcnt == WC_W'(WINDOW_CYCLES - 1));

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state_nx = S_MEASURE;
                S_MEASURE: if (last_cycle) state_nx = S_EVAL;
                S_EVAL:    state_nx = S_MEASURE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            window_done <= 1'b0;
        end else begin
            state       <= state_nx;
            window_done <= enable && last_cycle;
            if (enable && (state == S_MEASURE) && !last_cycle)
                wcnt <= wcnt + 1'b1;
            else
                wcnt <= '0;
        end
    end

    // Counters only run in MEASURE; IDLE, EVAL and a dropped enable all leave them at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!enable || (state != S_MEASURE))
                    cnt[i] <= '0;
                else if (bp_edge[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties
    always_comb begin
        win_code = 3'd0;
        win_cnt  = '0;
        for (int i = 0; i < 5; i++) begin
            if ((32'(cnt[i]) >= MIN_EDGES) && ((win_code == 3'd0) || (cnt[i] > win_cnt))) begin
                win_code = 3'(i + 1);
                win_cnt  = cnt[i];
            end
        end
    end

    always_comb begin
        cand_nx       = cand;
        streak_nx     = streak;
        tone_dir_nx   = tone_dir;
        tone_valid_nx = tone_valid;
        if (!enable) begin
            cand_nx       = 3'd0;
            streak_nx     = '0;
            tone_dir_nx   = 3'd0;
            tone_valid_nx = 1'b0;
        end else if (state == S_EVAL) begin
            if (win_code == cand) begin
                if (streak != ST_W'(CONFIRM))
                    streak_nx = streak + 1'b1;
            end else begin
                cand_nx   = win_code;
                streak_nx = ST_W'(1);
            end
            if (streak_nx == ST_W'(CONFIRM)) begin
                tone_dir_nx   = cand_nx;
                tone_valid_nx = 1'b1;
            end
        end
    end

    always_comb begin
        man_code = 3'd0;
        if (pb_s2[0])
            man_code = 3'd1;
        else if (pb_s2[1])
            man_code = 3'd2;
        else if (pb_s2[2])
            man_code = 3'd3;
        else if (pb_s2[3])
            man_code = 3'd4;
    end

    assign man_active = |pb_s2;

    // Outputs use the next tone state so a commit shows up the cycle right after EVAL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= 3'd0;
            streak     <= '0;
            tone_dir   <= 3'd0;
            tone_valid <= 1'b0;
            dir        <= 3'd0;
            dir_valid  <= 1'b0;
            source     <= 1'b0;
        end else begin
            cand       <= cand_nx;
            streak     <= streak_nx;
            tone_dir   <= tone_dir_nx;
            tone_valid <= tone_valid_nx;
            source     <= man_active;
            dir_valid  <= man_active | tone_valid_nx;
            if (man_active)
                dir <= man_code;
            else if (tone_valid_nx)
                dir <= tone_dir_nx;
            else
                dir <= 3'd0;
        end
    end

endmodule

// File: tb/tb_tone_window_scheduler.sv
// Directed bench for tone_window_scheduler: 100-cycle windows, MIN_EDGES=4, CONFIRM=2, 4-bit counters.
module tb_tone_window_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [4:0] bp = '0;
    logic [3:0] pb = '0;
    logic [2:0] dir;
    logic       dir_valid;
    logic       source;
    logic       window_done;

    int checks = 0;
    int failures = 0;

    logic       wd_rec  [1:101];
    logic [2:0] dir_rec [1:101];
    logic       src_rec [1:101];
    logic       dv_rec  [1:101];

    always #5 clk = ~clk;

    tone_window_scheduler #(
        .WINDOW_CYCLES(100),
        .CNT_W(4),
        .MIN_EDGES(4),
        .CONFIRM(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .bp(bp),
        .pb(pb),
        .dir(dir),
        .dir_valid(dir_valid),
        .source(source),
        .window_done(window_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full window (100 MEASURE cycles + EVAL), starting on the first MEASURE cycle.
    // Channel i pulses n_i times, one rising edge every two cycles from cycle 5.
    task automatic run_window(input int n0, input int n1, input int n2, input int n3, input int n4,
                              input int pb_on_j, input logic [3:0] pb_val, input int pb_off_j,
                              input int en_off_j);
        int n [5];
        n = '{n0, n1, n2, n3, n4};
        for (int j = 1; j <= 101; j++) begin
            for (int i = 0; i < 5; i++)
                bp[i] = (j >= 5) && (j < 5 + 2 * n[i]) && (((j - 5) % 2) == 0);
            if (j == pb_on_j) pb = pb_val;
            if (j == pb_off_j) pb = 4'b0000;
            if (j == en_off_j) enable = 1'b0;
            wd_rec[j]  = window_done;
            dir_rec[j] = dir;
            src_rec[j] = source;
            dv_rec[j]  = dir_valid;
            step();
        end
        bp = '0;
    endtask

    task automatic restart();
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bp = 5'($urandom);
            pb = 4'($urandom);
            step();
            checks++;
            if (dir !== 3'd0) begin failures++; $display("[TB] FAIL reset_dir: got %0d expected 0", dir); end
            checks++;
            if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_dir_valid: got %0b expected 0", dir_valid); end
            checks++;
            if (source !== 1'b0) begin failures++; $display("[TB] FAIL reset_source: got %0b expected 0", source); end
            checks++;
            if (window_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_window_done: got %0b expected 0", window_done); end
        end
        bp = '0;
        pb = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_commit();
        int ones;
        enable = 1'b1;
        checks++;
        if (window_done !== 1'b0) begin failures++; $display("[TB] FAIL idle_window_done: got %0b expected 0", window_done); end
        step();
        run_window(0, 0, 10, 0, 0, -1, 4'b0, -1, -1);
        ones = 0;
        for (int j = 1; j <= 100; j++) ones += int'(wd_rec[j]);
        checks++;
        if (ones != 0) begin failures++; $display("[TB] FAIL w1_early_done: got %0d pulses expected 0", ones); end
        checks++;
        if (wd_rec[101] !== 1'b1) begin failures++; $display("[TB] FAIL w1_done_at_101: got %0b expected 1", wd_rec[101]); end
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL w1_no_commit: got %0b expected 0", dir_valid); end
        run_window(0, 0, 10, 0, 0, -1, 4'b0, -1, -1);
        ones = 0;
        for (int j = 1; j <= 100; j++) ones += int'(wd_rec[j]);
        checks++;
        if (ones != 0) begin failures++; $display("[TB] FAIL w2_early_done: got %0d pulses expected 0", ones); end
        checks++;
        if (wd_rec[101] !== 1'b1) begin failures++; $display("[TB] FAIL w2_done_at_202: got %0b expected 1", wd_rec[101]); end
        checks++;
        if (dir_rec[101] !== 3'd0) begin failures++; $display("[TB] FAIL w2_dir_in_eval: got %0d expected 0", dir_rec[101]); end
        checks++;
        if (dir !== 3'd3) begin failures++; $display("[TB] FAIL commit_dir: got %0d expected 3", dir); end
        checks++;
        if (dir_valid !== 1'b1) begin failures++; $display("[TB] FAIL commit_dir_valid: got %0b expected 1", dir_valid); end
        checks++;
        if (source !== 1'b0) begin failures++; $display("[TB] FAIL commit_source: got %0b expected 0", source); end
    endtask

    task automatic test_tie();
        run_window(0, 8, 0, 8, 0, -1, 4'b0, -1, -1);
        checks++;
        if (dir !== 3'd3) begin failures++; $display("[TB] FAIL tie_hold_prev: got %0d expected 3", dir); end
        run_window(0, 8, 0, 8, 0, -1, 4'b0, -1, -1);
        checks++;
        if (dir !== 3'd2) begin failures++; $display("[TB] FAIL tie_lowest_index: got %0d expected 2", dir); end
        run_window(3, 3, 3, 3, 3, -1, 4'b0, -1, -1);
        checks++;
        if (dir !== 3'd2) begin failures++; $display("[TB] FAIL stop_hold_prev: got %0d expected 2", dir); end
        run_window(3, 3, 3, 3, 3, -1, 4'b0, -1, -1);
        checks++;
        if (dir !== 3'd0) begin failures++; $display("[TB] FAIL stop_dir: got %0d expected 0", dir); end
        checks++;
        if (dir_valid !== 1'b1) begin failures++; $display("[TB] FAIL stop_dir_valid: got %0b expected 1", dir_valid); end
        checks++;
        if (source !== 1'b0) begin failures++; $display("[TB] FAIL stop_source: got %0b expected 0", source); end
    endtask

    task automatic test_alternating();
        restart();
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL alt_cleared: got %0b expected 0", dir_valid); end
        run_window(6, 0, 0, 0, 0, -1, 4'b0, -1, -1);
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL alt_w1: got %0b expected 0", dir_valid); end
        run_window(0, 0, 0, 0, 6, -1, 4'b0, -1, -1);
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL alt_w2: got %0b expected 0", dir_valid); end
        run_window(6, 0, 0, 0, 0, -1, 4'b0, -1, -1);
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL alt_w3: got %0b expected 0", dir_valid); end
        run_window(6, 0, 0, 0, 0, -1, 4'b0, -1, -1);
        checks++;
        if (dir !== 3'd1) begin failures++; $display("[TB] FAIL alt_w4_dir: got %0d expected 1", dir); end
        checks++;
        if (dir_valid !== 1'b1) begin failures++; $display("[TB] FAIL alt_w4_valid: got %0b expected 1", dir_valid); end
    endtask

    task automatic test_override();
        restart();
        run_window(0, 0, 10, 0, 0, -1, 4'b0, -1, -1);
        run_window(0, 0, 10, 0, 0, -1, 4'b0, -1, -1);
        checks++;
        if (dir !== 3'd3) begin failures++; $display("[TB] FAIL ovr_base_dir: got %0d expected 3", dir); end
        run_window(0, 0, 10, 0, 0, 20, 4'b1010, 60, -1);
        checks++;
        if (dir_rec[22] !== 3'd3) begin failures++; $display("[TB] FAIL ovr_press_early: got %0d expected 3", dir_rec[22]); end
        checks++;
        if (dir_rec[23] !== 3'd2) begin failures++; $display("[TB] FAIL ovr_press_dir: got %0d expected 2", dir_rec[23]); end
        checks++;
        if (src_rec[23] !== 1'b1) begin failures++; $display("[TB] FAIL ovr_press_source: got %0b expected 1", src_rec[23]); end
        checks++;
        if (dv_rec[23] !== 1'b1) begin failures++; $display("[TB] FAIL ovr_press_valid: got %0b expected 1", dv_rec[23]); end
        checks++;
        if (dir_rec[62] !== 3'd2) begin failures++; $display("[TB] FAIL ovr_release_early: got %0d expected 2", dir_rec[62]); end
        checks++;
        if (dir_rec[63] !== 3'd3) begin failures++; $display("[TB] FAIL ovr_release_dir: got %0d expected 3", dir_rec[63]); end
        checks++;
        if (src_rec[63] !== 1'b0) begin failures++; $display("[TB] FAIL ovr_release_source: got %0b expected 0", src_rec[63]); end
        checks++;
        if (wd_rec[101] !== 1'b1) begin failures++; $display("[TB] FAIL ovr_window_done: got %0b expected 1", wd_rec[101]); end
        checks++;
        if (dir !== 3'd3) begin failures++; $display("[TB] FAIL ovr_after_dir: got %0d expected 3", dir); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dir !== 3'd0) begin failures++; $display("[TB] FAIL async_dir: got %0d expected 0", dir); end
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_dir_valid: got %0b expected 0", dir_valid); end
        checks++;
        if (source !== 1'b0) begin failures++; $display("[TB] FAIL async_source: got %0b expected 0", source); end
        step();
        rst_n = 1'b1;
        enable = 1'b0;
        step();
    endtask

    task automatic test_enable_in_eval();
        restart();
        run_window(0, 0, 10, 0, 0, -1, 4'b0, -1, -1);
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL eval_drop_w1: got %0b expected 0", dir_valid); end
        run_window(0, 0, 10, 0, 0, -1, 4'b0, -1, 101);
        checks++;
        if (wd_rec[101] !== 1'b1) begin failures++; $display("[TB] FAIL eval_drop_done: got %0b expected 1", wd_rec[101]); end
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL eval_drop_no_commit: got %0b expected 0", dir_valid); end
        checks++;
        if (dir !== 3'd0) begin failures++; $display("[TB] FAIL eval_drop_dir: got %0d expected 0", dir); end
        restart();
        run_window(0, 0, 10, 0, 0, -1, 4'b0, -1, -1);
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL eval_drop_streak_cleared: got %0b expected 0", dir_valid); end
        run_window(0, 0, 10, 0, 0, -1, 4'b0, -1, -1);
        checks++;
        if (dir !== 3'd3) begin failures++; $display("[TB] FAIL eval_drop_recommit: got %0d expected 3", dir); end
    endtask

    task automatic test_saturation();
        int ones;
        restart();
        run_window(12, 0, 0, 0, 40, -1, 4'b0, -1, -1);
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL sat_w1: got %0b expected 0", dir_valid); end
        run_window(12, 0, 0, 0, 40, -1, 4'b0, -1, -1);
        checks++;
        if (dir !== 3'd5) begin failures++; $display("[TB] FAIL sat_winner: got %0d expected 5", dir); end
        for (int k = 0; k < 50; k++) step();
        enable = 1'b0;
        checks++;
        if (dir !== 3'd5) begin failures++; $display("[TB] FAIL drop_same_cycle: got %0d expected 5", dir); end
        step();
        checks++;
        if (dir !== 3'd0) begin failures++; $display("[TB] FAIL drop_dir: got %0d expected 0", dir); end
        checks++;
        if (dir_valid !== 1'b0) begin failures++; $display("[TB] FAIL drop_dir_valid: got %0b expected 0", dir_valid); end
        ones = 0;
        for (int k = 0; k < 120; k++) begin
            step();
            ones += int'(window_done);
        end
        checks++;
        if (ones != 0) begin failures++; $display("[TB] FAIL idle_no_windows: got %0d pulses expected 0", ones); end
        pb = 4'b0100;
        step();
        step();
        checks++;
        if (dir !== 3'd0) begin failures++; $display("[TB] FAIL idle_press_early: got %0d expected 0", dir); end
        step();
        checks++;
        if (dir !== 3'd3) begin failures++; $display("[TB] FAIL idle_press_dir: got %0d expected 3", dir); end
        checks++;
        if (source !== 1'b1 || dir_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_press_flags: got source=%0b valid=%0b expected 1/1", source, dir_valid);
        end
        pb = 4'b0000;
        step();
        step();
        step();
        checks++;
        if (dir !== 3'd0 || dir_valid !== 1'b0 || source !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_release: got dir=%0d valid=%0b source=%0b expected 0/0/0", dir, dir_valid, source);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_tie();
        test_alternating();
        test_override();
        test_async_reset();
        test_enable_in_eval();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
